// File: rtl/uart_tx_mmio_if.sv
// Processor-side bus for the memory-mapped UART transmitter.
// Carries the EX_MEM store/load strobes, the byte address, the store data and
// the combinational load data returned to MEM_WB.
interface uart_tx_mmio_if;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   // Pipeline side: issues the strobes, consumes ReadData.
   modport master (
      output MemWrite,
      output MemRead,
      output Address,
      output WriteData,
      input  ReadData
   );

   // Peripheral side: decodes the strobes, drives ReadData.
   modport slave (
      input  MemWrite,
      input  MemRead,
      input  Address,
      input  WriteData,
      output ReadData
   );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter (8N1, LSB first, optional even parity).
//   DATA   at BASE_ADDR     : store pushes WriteData[7:0] into the TX FIFO.
//   STATUS at BASE_ADDR + 4 : load returns {par_en, 19'b0, count[7:0], overflow, empty, full, busy};
//                             store clears the sticky overflow flag.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (11-bit frame, STATUS bit 31 reads 1).
//
// Bus strobe semantics: there is no valid/ready pair on this bus. A store or
// load is a single-cycle strobe (MemWrite / MemRead) qualified by an exact
// 32-bit address match; the peripheral never stalls the pipeline. A store is
// acted on at the rising edge where it is high, a load is answered
// combinationally in the same cycle and has no side effects.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR    = 32'h1001_0100,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic           clk,
   input  logic           reset,
   uart_tx_mmio_if.slave  bus,
   output logic           TxD,
   output logic           TxBusy,
   output logic [2:0]     dbg_state
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
   localparam logic PAR_FLAG = 1'b1;
`else
   localparam logic PAR_FLAG = 1'b0;
`endif

   // Encoding is fixed so the debug output means the same thing in both builds.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   // ---------------------------------------------------------------
   // Address decode and bus strobes
   // ---------------------------------------------------------------
   logic sel_data;
   logic sel_stat;
   logic push_req;
   logic clr_ovf;

   assign sel_data = (bus.Address == BASE_ADDR);
   assign sel_stat = (bus.Address == (BASE_ADDR + 32'd4));
   assign push_req = bus.MemWrite & sel_data;
   assign clr_ovf  = bus.MemWrite & sel_stat;

   // Only the low byte of a DATA store is meaningful.
   logic unused_wdata;
   assign unused_wdata = ^bus.WriteData[31:8];

   // ---------------------------------------------------------------
   // TX FIFO storage and control
   // ---------------------------------------------------------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic [7:0]    head;

   // ---------------------------------------------------------------
   // Serialiser state
   // ---------------------------------------------------------------
   state_e        state;
   logic [TW-1:0] clk_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          txd;
   logic          bit_end;
   logic          busy;
`ifdef UART_TX_PARITY_EN
   logic          par_bit;
`endif

   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign head    = mem[rd_ptr];
   assign bit_end = (clk_cnt == TW'(CLKS_PER_BIT - 1));

   // The serialiser takes the head byte either from IDLE or on the final
   // cycle of a stop bit, so back-to-back frames have no idle gap.
   assign pop  = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

   // A store into a full FIFO still lands if the head leaves on the same edge.
   assign push = push_req && (!full || pop);

   assign busy = (state != S_IDLE) || !empty;

   // FIFO storage: written on accepted pushes; contents need no reset because
   // count/pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.WriteData[7:0];
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow: set when a DATA store is dropped, cleared by any STATUS store.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end else if (push_req && !push) begin
         overflow <= 1'b1;
      end
   end

   // Bit-timing FSM: TxD is registered here alongside the state so every
   // line transition lines up with the state change that causes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               txd     <= 1'b1;
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (pop) begin
                  shreg <= head;
`ifdef UART_TX_PARITY_EN
                  par_bit <= ^head;
`endif
                  txd   <= 1'b0;
                  state <= S_START;
               end
            end

            S_START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  txd     <= shreg[0];
                  state   <= S_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     txd   <= par_bit;
                     state <= S_PARITY;
`else
                     txd   <= 1'b1;
                     state <= S_STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= {1'b0, shreg[7:1]};
                     txd     <= shreg[1];
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            S_PARITY: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  txd     <= 1'b1;
                  state   <= S_STOP;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (pop) begin
                     shreg <= head;
`ifdef UART_TX_PARITY_EN
                     par_bit <= ^head;
`endif
                     txd   <= 1'b0;
                     state <= S_START;
                  end else begin
                     txd   <= 1'b1;
                     state <= S_IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            default: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               txd     <= 1'b1;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   // Load data: STATUS flags on a STATUS read, zero for DATA and unmapped reads.
   logic [7:0] cnt8;
   assign cnt8 = 8'(count);

   always_comb begin
      bus.ReadData = 32'h0;
      if (bus.MemRead && sel_stat) begin
         bus.ReadData = {PAR_FLAG, 19'b0, cnt8, overflow, empty, full, busy};
      end else if (bus.MemRead && sel_data) begin
         bus.ReadData = {24'b0, 8'h00};
      end
   end

   assign TxD       = txd;
   assign TxBusy    = busy;
   assign dbg_state = state;

endmodule
